// File: rtl/serial_deserializer.sv
// serial_deserializer: serial-in/parallel-out receiver.
// Assembles an N-bit word from one bit per accepted cycle, in LSB-first or
// MSB-first order. The order is chosen by dir on the first bit of a frame.
// Completed words are presented on a valid/ready port with a single holding
// slot. A completed word that finds the slot occupied is dropped, and the
// drop sets the sticky overrun flag.
// Optional feature macro: DESER_PARITY_EN. When it is defined, each frame
// carries one extra even-parity bit after the data, and parity_err reports
// the result of that check for the word held in m_data.
module serial_deserializer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  input  logic         s_bit,
  input  logic         dir,
  output logic [N-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         busy,
  output logic         overrun,
  output logic         parity_err
);

  localparam int CW = $clog2(N + 1);

`ifdef DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t         r_state;
  state_t         w_state_next;
  logic [N-1:0]   r_sr;
  logic [N-1:0]   w_sr_next;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_next;
  logic           r_dir_q;
  logic           w_dir_next;
  logic           w_dir_eff;
  logic [N-1:0]   w_shifted;
  logic           w_done;
  logic [N-1:0]   w_word;
  logic           w_slot_free;
  logic [N-1:0]   r_m_data;
  logic           r_m_valid;
  logic           r_overrun;
`ifdef DESER_PARITY_EN
  logic           w_perr;
  logic           r_parity_err;
`endif

  // The frame's first bit uses the live dir input. Later bits use the order latched at frame start.
  assign w_dir_eff   = (r_state == IDLE) ? dir : r_dir_q;
  assign w_shifted   = w_dir_eff ? {s_bit, r_sr[N-1:1]} : {r_sr[N-2:0], s_bit};
  assign w_slot_free = !r_m_valid || m_ready;

  // Next-state, shift-register and completion decode for the frame assembler.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    w_state_next = r_state;
    w_sr_next    = r_sr;
    w_cnt_next   = r_cnt;
    w_dir_next   = r_dir_q;
    w_done       = 1'b0;
    w_word       = r_sr;
`ifdef DESER_PARITY_EN
    w_perr       = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        // N >= 2, so the first bit can never complete a frame here.
        if (s_valid) begin
          w_dir_next   = dir;
          w_sr_next    = w_shifted;
          w_cnt_next   = CW'(1);
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (s_valid) begin
          w_sr_next = w_shifted;
          if (r_cnt == CW'(N - 1)) begin
`ifdef DESER_PARITY_EN
            w_cnt_next   = CW'(N);
            w_state_next = PARITY;
`else
            w_cnt_next   = '0;
            w_state_next = IDLE;
            w_done       = 1'b1;
            w_word       = w_shifted;
`endif
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
      end
`ifdef DESER_PARITY_EN
      PARITY: begin
        // The parity bit is checked, not stored. Even parity means the data bits and the parity bit XOR to 0.
        if (s_valid) begin
          w_done       = 1'b1;
          w_word       = r_sr;
          w_perr       = ^{r_sr, s_bit};
          w_cnt_next   = '0;
          w_state_next = IDLE;
        end
      end
`endif
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so all registers update together from pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Frame assembly registers: shift register, bit count, and latched bit order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr    <= '0;
      r_cnt   <= '0;
      r_dir_q <= 1'b0;
    end else begin
      r_sr    <= w_sr_next;
      r_cnt   <= w_cnt_next;
      r_dir_q <= w_dir_next;
    end
  end

  // Output holding slot: load on completion if free, otherwise record the drop; clear on transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_data     <= '0;
      r_m_valid    <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef DESER_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else if (w_done) begin
      if (w_slot_free) begin
        r_m_data     <= w_word;
        r_m_valid    <= 1'b1;
`ifdef DESER_PARITY_EN
        r_parity_err <= w_perr;
`endif
      end else begin
        r_overrun    <= 1'b1;
      end
    end else if (r_m_valid && m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign busy    = (r_state != IDLE);
  assign overrun = r_overrun;
`ifdef DESER_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// tb_serial_deserializer: bench for serial_deserializer. It uses directed
// scenarios and randomized traffic. The reference model keeps each frame as a
// queue of bits and builds the word arithmetically from the bit order.
module tb_serial_deserializer;

  localparam int N = 4;
`ifdef DESER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = N + PAR;

  logic         clk;
  logic         rst;
  logic         s_valid;
  logic         s_bit;
  logic         dir;
  logic [N-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  serial_deserializer #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_bit      (s_bit),
    .dir        (dir),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  bit           frame_bits[$];
  bit           frame_dir;
  logic [N-1:0] mdl_data;
  bit           mdl_valid;
  bit           mdl_ovr;
  bit           mdl_perr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Apply one edge's worth of inputs to the model.
  task automatic model_step(input bit r, input bit sv, input bit b, input bit d, input bit rdy);
    bit           done;
    logic [N-1:0] w;
    bit           p;
    done = 0;
    w    = '0;
    p    = 0;
    if (r) begin
      frame_bits.delete();
      mdl_data  = '0;
      mdl_valid = 0;
      mdl_ovr   = 0;
      mdl_perr  = 0;
      return;
    end
    if (sv) begin
      if (frame_bits.size() == 0) frame_dir = d;
      frame_bits.push_back(b);
      if (frame_bits.size() == FLEN) begin
        for (int i = 0; i < N; i++) begin
          if (frame_dir) w[i] = frame_bits[i];
          else           w[N-1-i] = frame_bits[i];
        end
        for (int i = 0; i < FLEN; i++) p = p ^ frame_bits[i];
        if (PAR == 0) p = 0;
        frame_bits.delete();
        done = 1;
      end
    end
    if (done) begin
      if (!mdl_valid || rdy) begin
        mdl_data  = w;
        mdl_valid = 1;
        mdl_perr  = p;
      end else begin
        mdl_ovr = 1;
      end
    end else if (mdl_valid && rdy) begin
      mdl_valid = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".m_data"},     32'(m_data),     32'(mdl_data));
    check({tag, ".m_valid"},    32'(m_valid),    32'(mdl_valid));
    check({tag, ".busy"},       32'(busy),       32'(frame_bits.size() != 0));
    check({tag, ".overrun"},    32'(overrun),    32'(mdl_ovr));
    check({tag, ".parity_err"}, 32'(parity_err), 32'(mdl_perr));
  endtask

  // One clock cycle: drive inputs, step the model at the edge, compare at the falling edge.
  task automatic cyc(input bit r, input bit sv, input bit b, input bit d, input bit rdy, input string tag);
    rst     = r;
    s_valid = sv;
    s_bit   = b;
    dir     = d;
    m_ready = rdy;
    @(posedge clk);
    model_step(r, sv, b, d, rdy);
    @(negedge clk);
    compare_all(tag);
  endtask

  // Send one full frame. m_ready is rdy_o on every bit except the last, which uses rdy_l.
  task automatic send_word(input logic [N-1:0] w, input bit d, input bit rdy_o, input bit rdy_l,
                           input bit bad_par, input string tag);
    bit b;
    bit last;
    for (int i = 0; i < N; i++) begin
      b    = d ? w[i] : w[N-1-i];
      last = (i == N - 1) && (PAR == 0);
      cyc(0, 1, b, d, last ? rdy_l : rdy_o, tag);
    end
    if (PAR != 0) cyc(0, 1, (^w) ^ bad_par, d, rdy_l, tag);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_bit = 1'b0; dir = 1'b0; m_ready = 1'b0;
    mdl_data = '0; mdl_valid = 0; mdl_ovr = 0; mdl_perr = 0; frame_dir = 0;

    // Reset held with s_valid active.
    cyc(1, 1, 1, 1, 0, "rst");
    cyc(1, 1, 1, 1, 0, "rst");
    check("rst_m_data",  32'(m_data),  32'h0);
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_perr",    32'(parity_err), 32'h0);

    // LSB-first 1,0,1,1.
    cyc(0, 1, 1, 1, 0, "lsb");
    check("lsb_busy_mid", 32'(busy), 32'h1);
    cyc(0, 1, 0, 1, 0, "lsb");
    cyc(0, 1, 1, 1, 0, "lsb");
    cyc(0, 1, 1, 1, 0, "lsb");
    if (PAR != 0) cyc(0, 1, 1'b1, 1, 0, "lsb");
    check("lsb_m_data",  32'(m_data),  32'hD);
    check("lsb_m_valid", 32'(m_valid), 32'h1);
    check("lsb_busy",    32'(busy),    32'h0);
    cyc(0, 0, 0, 0, 1, "lsb_drain");
    check("lsb_drained", 32'(m_valid), 32'h0);

    // MSB-first with gaps, dir toggled after the first bit.
    cyc(0, 1, 1, 0, 0, "msb");
    cyc(0, 0, 0, 1, 0, "msb");
    cyc(0, 1, 0, 1, 0, "msb");
    cyc(0, 0, 1, 1, 0, "msb");
    cyc(0, 1, 1, 1, 0, "msb");
    cyc(0, 0, 0, 1, 0, "msb");
    cyc(0, 1, 1, 1, 0, "msb");
    if (PAR != 0) cyc(0, 1, 1'b1, 1, 0, "msb");
    check("msb_m_data",  32'(m_data),  32'hB);
    check("msb_m_valid", 32'(m_valid), 32'h1);
    cyc(0, 0, 0, 0, 1, "msb_drain");

    // Backpressure and overrun.
    send_word(4'hA, 1, 0, 0, 0, "bp");
    send_word(4'h5, 1, 0, 0, 0, "bp");
    check("bp_m_data",  32'(m_data),  32'hA);
    check("bp_overrun", 32'(overrun), 32'h1);
    cyc(0, 0, 0, 0, 1, "bp_drain");
    check("bp_valid_after", 32'(m_valid), 32'h0);
    check("bp_ovr_sticky",  32'(overrun), 32'h1);
    cyc(1, 0, 0, 0, 0, "bp_rst");

    // Simultaneous completion and drain, then reset mid-frame.
    send_word(4'h3, 0, 0, 0, 0, "sim");
    send_word(4'hC, 0, 0, 1, 0, "sim");
    check("sim_m_data",  32'(m_data),  32'hC);
    check("sim_m_valid", 32'(m_valid), 32'h1);
    check("sim_overrun", 32'(overrun), 32'h0);
    cyc(0, 1, 1, 1, 0, "mid");
    cyc(0, 1, 0, 1, 0, "mid");
    check("mid_busy", 32'(busy), 32'h1);
    cyc(1, 0, 0, 0, 0, "mid_rst");
    check("mid_rst_busy",  32'(busy),    32'h0);
    check("mid_rst_valid", 32'(m_valid), 32'h0);
    // A fresh frame after reset must take a full N bits again.
    send_word(4'h6, 1, 0, 0, 0, "post_rst");
    check("post_rst_data", 32'(m_data), 32'h6);
    cyc(0, 0, 0, 0, 1, "post_rst_drain");

`ifdef DESER_PARITY_EN
    // Parity good and bad, on the same data.
    send_word(4'b0011, 1, 0, 0, 0, "par_ok");
    check("par_ok_data", 32'(m_data),     32'h3);
    check("par_ok_perr", 32'(parity_err), 32'h0);
    cyc(0, 0, 0, 0, 1, "par_drain");
    send_word(4'b0011, 1, 0, 0, 1, "par_bad");
    check("par_bad_data", 32'(m_data),     32'h3);
    check("par_bad_perr", 32'(parity_err), 32'h1);
    cyc(0, 0, 0, 0, 1, "par_drain");
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), 1'($urandom),
          1'($urandom), ($urandom_range(0, 9) < 5), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guards against a stalled simulation.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

- Serial-in/parallel-out (SIPO) deserializer.
- Receive side of the team's parallel-load shift path: collects an N-bit word one bit per accepted cycle, in either shift direction, and presents it on a valid/ready output port.
- Sits between a serial link or shift stage and word-wide consumers such as the ALU operand registers.
- Frame assembly, output holding register, overrun detection and optional parity checking are all internal.

## Interface
- N, 4, data word width; legal range N ≥ 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  serial bit present this cycle
- s_bit  in  1  serial data bit, sampled when s_valid=1
- dir  in  1  bit order of the frame: 1 = LSB first (right-shift fill), 0 = MSB first (left-shift fill)
- m_data  out  N  assembled word
- m_valid  out  1  m_data holds an unconsumed word
- m_ready  in  1  consumer accepts m_data when m_valid=1
- busy  out  1  frame in progress (at least one bit accepted, frame not complete)
- overrun  out  1  sticky; a completed word was dropped
- parity_err  out  1  parity error flag for the word in m_data (see Configuration)

## Operation
- State machine: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- IDLE:
  - cnt=0, busy=0.
  - s_valid=1 latches dir into dir_q, shifts in s_bit, sets cnt=1 and moves to SHIFT.
  - Exception, N=1 is illegal, so IDLE never completes a frame.
- SHIFT, on each s_valid=1:
  - dir_q=1: sr ← {s_bit, sr[N-1:1]}.
  - dir_q=0: sr ← {sr[N-2:0], s_bit}.
  - cnt increments.
  - The N-th accepted bit completes the data phase. Without the macro: word complete, go to IDLE. With the macro: go to PARITY.
- s_valid=0 cycles are gaps: no shift, no count change, no timeout.
- dir is sampled only on the first bit of a frame; changes mid-frame are ignored.
- Word completion, output slot free (m_valid=0, or m_valid=1 and m_ready=1 in the same cycle):
  - m_data ← assembled word.
  - m_valid ← 1.
- Word completion, slot occupied and not drained:
  - Word discarded; m_data and m_valid unchanged.
  - overrun ← 1.
- Handshake:
  - Transfer occurs on a cycle with m_valid=1 and m_ready=1.
  - m_valid falls the next cycle unless a new word loads in the same cycle.
  - m_data is stable while m_valid=1 and not accepted.
- overrun clears only on rst.
- Reset mid-frame discards partial sr/cnt and returns to IDLE; a held word is lost.

## Timing
- Reset values: m_data=0, m_valid=0, busy=0, overrun=0, parity_err=0, sr=0, cnt=0, state=IDLE.
- Latency:
  - Last frame bit accepted at edge k gives m_valid=1 and m_data valid after edge k.
  - Back-to-back frames: the first bit of the next frame is accepted on the cycle after the last bit. No dead cycle.
- busy rises after the first accepted bit and falls after the edge completing the frame.
- Simultaneous completion and drain: the new word loads, m_valid stays 1, no overrun.
- rst has priority over all other inputs in the same cycle.

## Configuration
- DESER_PARITY_EN defined:
  - Each frame carries one extra bit after the N data bits.
  - Even parity: XOR of data bits and parity bit must be 0.
  - parity_err loads with m_data. It is 1 if the check fails and is not updated on an overrun drop.
  - The word is delivered regardless of parity result.
- DESER_PARITY_EN undefined:
  - Frame is exactly N bits; PARITY state is not built.
  - parity_err tied to 0.

## Test plan
- Reset: assert rst with s_valid=1 for 2 cycles. Outputs must be m_data=0, m_valid=0, busy=0, overrun=0, parity_err=0.
- LSB-first: N=4, dir=1, bits 1,0,1,1 on consecutive cycles. Required: m_data=4'b1101, m_valid=1 the cycle after the 4th bit, busy back to 0.
- MSB-first with gaps: dir=0, bits 1,0,1,1 with s_valid=0 cycles between them, and dir toggled after bit 1. Required: m_data=4'b1011 (dir change ignored).
- Backpressure and overrun: m_ready=0, send word 4'hA, then word 4'h5. Required: m_data stays 4'hA, overrun=1 after the second frame. Then m_ready=1: the transfer completes and overrun stays 1.
- Simultaneous drain: hold 4'h3, raise m_ready on the same cycle as the last bit of 4'hC. Required: m_data=4'hC, m_valid=1, overrun=0. Follow with rst after 2 bits of a new frame: cnt=0, busy=0, m_valid=0.
- With DESER_PARITY_EN: LSB-first data 1,1,0,0 with parity 0 gives 4'b0011, parity_err=0. The same data with parity 1 gives parity_err=1.
